// File: rtl/modcore_axil_pkg.sv
// Shared types and constants for the modcore AXI4-Lite request scheduler.
package modcore_axil_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_AW_W,
      WR_B,
      RD_AR,
      RD_R,
      DONE
   } state_t;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;
   localparam logic [1:0] RESP_DECERR  = 2'b11;
   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // Any response other than OKAY counts as an error (EXOKAY is not used on AXI-Lite).
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/modcore_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the
// pointer with wrap-around; the pointer moves past the winner on each accept.
module modcore_rr_arbiter #(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          accept,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_reg;
   logic [IW:0]   sum;
   logic [IW-1:0] idx;
   logic          found;

   // Pick the first active request at or after the pointer, wrapping at N.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_reg} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         idx = sum[IW-1:0];
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   // Advance the pointer to the requester after the winner, only when a grant is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (accept) begin
         ptr_reg <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/modcore_axil_sched.sv
// Schedules single-outstanding AXI4-Lite transactions from NUM_REQ requesters
// onto one master port, with per-requester completion pulses and error status.
module modcore_axil_sched
   import modcore_axil_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic [NUM_REQ-1:0]          REQ_VALID,
   output logic [NUM_REQ-1:0]          REQ_READY,
   input  logic [NUM_REQ-1:0]          REQ_WE,
   input  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR,
   input  logic [NUM_REQ*DATA_W-1:0]   REQ_WDATA,
   input  logic [NUM_REQ*DATA_W/8-1:0] REQ_WSTRB,
   output logic [NUM_REQ-1:0]          RSP_VALID,
   output logic [DATA_W-1:0]           RSP_RDATA,
   output logic [1:0]                  RSP_RESP,
   output logic [ADDR_W-1:0]           M_AXI_AWADDR,
   output logic [2:0]                  M_AXI_AWPROT,
   output logic                        M_AXI_AWVALID,
   input  logic                        M_AXI_AWREADY,
   output logic [DATA_W-1:0]           M_AXI_WDATA,
   output logic [DATA_W/8-1:0]         M_AXI_WSTRB,
   output logic                        M_AXI_WVALID,
   input  logic                        M_AXI_WREADY,
   input  logic [1:0]                  M_AXI_BRESP,
   input  logic                        M_AXI_BVALID,
   output logic                        M_AXI_BREADY,
   output logic [ADDR_W-1:0]           M_AXI_ARADDR,
   output logic [2:0]                  M_AXI_ARPROT,
   output logic                        M_AXI_ARVALID,
   input  logic                        M_AXI_ARREADY,
   input  logic [DATA_W-1:0]           M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP,
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY,
   output logic                        BUSY,
   output logic                        ERROR,
   input  logic                        ERR_CLR,
   output logic [7:0]                  ERR_CNT
);

   localparam int SW = DATA_W / 8;
   localparam int IW = $clog2(NUM_REQ);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [SW-1:0]       wstrb_reg;
   logic [IW-1:0]       gidx_reg;
   logic                aw_done_reg, w_done_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic [1:0]          resp_reg;
   logic                error_reg;
   logic [7:0]          err_cnt_reg;

   logic [NUM_REQ-1:0]  grant;
   logic [IW-1:0]       grant_idx;
   logic                accept;
   logic                aw_hs, w_hs;

   logic [ADDR_W-1:0]   req_addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   req_wdata_arr [NUM_REQ];
   logic [SW-1:0]       req_wstrb_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_addr_arr[gi]  = REQ_ADDR[gi*ADDR_W +: ADDR_W];
         assign req_wdata_arr[gi] = REQ_WDATA[gi*DATA_W +: DATA_W];
         assign req_wstrb_arr[gi] = REQ_WSTRB[gi*SW +: SW];
      end
   endgenerate

   modcore_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (ACLK),
      .rst       (ARESET),
      .req       (REQ_VALID),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // A command is taken whenever the scheduler is idle and anyone is asking.
   assign accept = (state_reg == IDLE) && (|REQ_VALID);
   // Channel handshakes derived from state so they never depend on the output ports.
   assign aw_hs  = (state_reg == WR_AW_W) && !aw_done_reg && M_AXI_AWREADY;
   assign w_hs   = (state_reg == WR_AW_W) && !w_done_reg && M_AXI_WREADY;

   assign M_AXI_AWADDR = addr_reg;
   assign M_AXI_ARADDR = addr_reg;
   assign M_AXI_AWPROT = PROT_DEFAULT;
   assign M_AXI_ARPROT = PROT_DEFAULT;
   assign M_AXI_WDATA  = wdata_reg;
   assign M_AXI_WSTRB  = wstrb_reg;
   assign RSP_RDATA    = rdata_reg;
   assign RSP_RESP     = resp_reg;
   assign BUSY         = (state_reg != IDLE);
   assign ERROR        = error_reg;
   assign ERR_CNT      = err_cnt_reg;

   // State register; reset aborts any in-flight transaction at once.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode and per-state channel valid/ready outputs.
   always_comb begin
      state_next    = state_reg;
      REQ_READY     = '0;
      RSP_VALID     = '0;
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      case (state_reg)
         IDLE: begin
            REQ_READY = grant;
            if (accept) begin
               state_next = REQ_WE[grant_idx] ? WR_AW_W : RD_AR;
            end
         end
         WR_AW_W: begin
            M_AXI_AWVALID = !aw_done_reg;
            M_AXI_WVALID  = !w_done_reg;
            if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
               state_next = WR_B;
            end
         end
         WR_B: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) begin
               state_next = DONE;
            end
         end
         RD_AR: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) begin
               state_next = RD_R;
            end
         end
         RD_R: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) begin
               state_next = DONE;
            end
         end
         DONE: begin
            RSP_VALID[gidx_reg] = 1'b1;
            state_next          = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Command capture, channel-done tracking and response capture.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         gidx_reg    <= '0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         rdata_reg   <= '0;
         resp_reg    <= RESP_OKAY;
      end else begin
         if (accept) begin
            addr_reg    <= req_addr_arr[grant_idx];
            wdata_reg   <= req_wdata_arr[grant_idx];
            wstrb_reg   <= req_wstrb_arr[grant_idx];
            gidx_reg    <= grant_idx;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= RESP_OKAY;
         end
         if (aw_hs) begin
            aw_done_reg <= 1'b1;
         end
         if (w_hs) begin
            w_done_reg <= 1'b1;
         end
         if (state_reg == WR_B && M_AXI_BVALID) begin
            resp_reg <= M_AXI_BRESP;
         end
         if (state_reg == RD_R && M_AXI_RVALID) begin
            rdata_reg <= M_AXI_RDATA;
            resp_reg  <= M_AXI_RRESP;
         end
      end
   end

   // Sticky error and saturating count; a new error beats a simultaneous clear.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         error_reg   <= 1'b0;
         err_cnt_reg <= '0;
      end else if (state_reg == DONE && resp_is_err(resp_reg)) begin
         error_reg <= 1'b1;
         if (ERR_CLR) begin
            err_cnt_reg <= 8'd1;
         end else if (err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
         end
      end else if (ERR_CLR) begin
         error_reg   <= 1'b0;
         err_cnt_reg <= '0;
      end
   end

endmodule
